mem_end_tracker: RTL

- Tracks outstanding memory transactions per memory port and produces the per-port memDone handshakes consumed by end_sync_dataless (its memDone_valid/memDone_ready vector).
- Accepts the function-end control token, then drains: a port's memDone is raised only once that port has zero outstanding transactions.
- Sits between the memory controllers' issue/retire signalling and the end synchronizer.
- Sequences termination so the end token is released only after all memory traffic has retired.

---
 rtl/mem_end_tracker_pkg.sv | 19 +
 rtl/outstanding_counter.sv | 45 ++++
 rtl/mem_end_tracker.sv | 107 ++++++++++
 3 files changed

// File: rtl/mem_end_tracker_pkg.sv
// Shared types and constants for the memory end-of-function tracker.
// Holds the FSM state encoding and the helper that sizes the outstanding counters.
package mem_end_tracker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned CNT_WIDTH_DEFAULT = 8;
  localparam int unsigned CNT_MAX_DEFAULT   = (1 << CNT_WIDTH_DEFAULT) - 1;

  // Saturation value of a counter of the given width (widths up to 31 bits).
  function automatic int unsigned cnt_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/outstanding_counter.sv
// Per-port outstanding-transaction counter: saturates at max, holds at zero,
// and flags the offending pulse on overflow/underflow.
module outstanding_counter
  import mem_end_tracker_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  input  logic retire,
  output logic zero,
  output logic ovf,
  output logic udf
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(cnt_max(CNT_WIDTH));

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 at_max;

  assign zero   = (cnt_q == '0);
  assign at_max = (cnt_q == CNT_MAX);
  assign ovf    = issue & ~retire & at_max;
  assign udf    = retire & ~issue & zero;

  always_comb begin
    cnt_d = cnt_q;
    if (issue && !retire && !at_max) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else if (retire && !issue && !zero) begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_end_tracker.sv
// Accepts the function-end token, waits for each memory port to drain to zero
// outstanding transactions, and hands out one memDone handshake per port.
module mem_end_tracker
  import mem_end_tracker_pkg::*;
#(
  parameter int MEM_PORTS = 2,
  parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ctrlEnd_valid,
  output logic                 ctrlEnd_ready,
  input  logic [MEM_PORTS-1:0] issue,
  input  logic [MEM_PORTS-1:0] retire,
  output logic [MEM_PORTS-1:0] memDone_valid,
  input  logic [MEM_PORTS-1:0] memDone_ready,
  output logic                 busy,
  output logic                 err
);

  logic [MEM_PORTS-1:0] zero;
  logic [MEM_PORTS-1:0] ovf;
  logic [MEM_PORTS-1:0] udf;

  for (genvar gi = 0; gi < MEM_PORTS; gi++) begin : g_port
    outstanding_counter #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .issue (issue[gi]),
      .retire(retire[gi]),
      .zero  (zero[gi]),
      .ovf   (ovf[gi]),
      .udf   (udf[gi])
    );
  end

  state_t               state_q, state_d;
  logic [MEM_PORTS-1:0] done_q, done_d;
  logic [MEM_PORTS-1:0] ack_q, ack_d;
  logic [MEM_PORTS-1:0] memDone_valid_q, memDone_valid_d;
  logic                 ctrlEnd_ready_q;
  logic                 busy_q;
  logic                 err_q, err_d;

  always_comb begin
    state_d         = state_q;
    done_d          = done_q;
    ack_d           = ack_q;
    memDone_valid_d = '0;
    err_d           = err_q | (|ovf) | (|udf);
    case (state_q)
      IDLE: begin
        if (ctrlEnd_valid) begin
          state_d = DRAIN;
          done_d  = '0;
          ack_d   = '0;
        end
      end
      DRAIN: begin
        done_d = done_q | (zero & ~issue);
        ack_d  = ack_q | (memDone_valid_q & memDone_ready);
        // New traffic on a port already offering done cannot revoke it.
        err_d  = err_d | (|(issue & done_q & ~ack_q));
        if (&ack_d) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = '0;
        ack_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == DRAIN) begin
      memDone_valid_d = done_d & ~ack_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      done_q          <= '0;
      ack_q           <= '0;
      memDone_valid_q <= '0;
      ctrlEnd_ready_q <= 1'b1;
      busy_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      done_q          <= done_d;
      ack_q           <= ack_d;
      memDone_valid_q <= memDone_valid_d;
      ctrlEnd_ready_q <= (state_d == IDLE);
      busy_q          <= (state_d != IDLE);
      err_q           <= err_d;
    end
  end

  assign memDone_valid = memDone_valid_q;
  assign ctrlEnd_ready = ctrlEnd_ready_q;
  assign busy          = busy_q;
  assign err           = err_q;

endmodule
